data_packer: RTL and testbench

DATA_PACKER -- requirements
Module: data_packer

---
 rtl/data_packer.sv | 213 +++++++++++++++++++++
 tb/tb_data_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_packer.sv
// data_packer: packs 1/4/8-bit input slices into LowDimWidth-bit words, or passes full words
// through in mode 0, and queues the results in a small non-fallthrough output FIFO.
// A word is emitted when the slice chunk fills the word or when an element of
// csr_elem_size_i slices ends (size 0 = unbounded elements).
// Optional feature: define DATA_PACKER_STATUS_EN to add word_count_o, a wrapping count of
// pushed words.
module data_packer #(
    parameter int unsigned LowDimWidth     = 64,
    parameter int unsigned CsrRegWidth     = 32,
    parameter int unsigned PackerFifoDepth = 4,
    parameter int unsigned ModeWidth       = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   clr_i,
    input  logic [ModeWidth-1:0]   sel_mode_i,
    input  logic [CsrRegWidth-1:0] csr_elem_size_i,
    input  logic [LowDimWidth-1:0] in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [LowDimWidth-1:0] out_data_o,
    output logic                   out_valid_o,
`ifdef DATA_PACKER_STATUS_EN
    output logic [CsrRegWidth-1:0] word_count_o,
`endif
    input  logic                   out_ready_i
);

    localparam int unsigned ChunkW = $clog2(LowDimWidth);
    localparam int unsigned PtrW   = (PackerFifoDepth > 1) ? $clog2(PackerFifoDepth) : 1;
    localparam int unsigned CntW   = $clog2(PackerFifoDepth + 1);

    localparam logic [ChunkW-1:0] LastChunk1 = ChunkW'(LowDimWidth - 1);
    localparam logic [ChunkW-1:0] LastChunk4 = ChunkW'(LowDimWidth / 4 - 1);
    localparam logic [ChunkW-1:0] LastChunk8 = ChunkW'(LowDimWidth / 8 - 1);
    localparam logic [PtrW-1:0]   LastPtr    = PtrW'(PackerFifoDepth - 1);
    localparam logic [CntW-1:0]   FullCnt    = CntW'(PackerFifoDepth);

    // Packer state
    logic [ChunkW-1:0]      chunk_q, chunk_d;
    logic [CsrRegWidth-1:0] elem_q, elem_d;
    logic [LowDimWidth-1:0] asm_q, asm_d;

    // FIFO state
    logic [LowDimWidth-1:0] mem_q [PackerFifoDepth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;

    // Mode decode
    logic                   full_mode;
    logic [LowDimWidth-1:0] slice_mask;
    logic [ChunkW-1:0]      last_chunk;
    logic [ChunkW-1:0]      bit_offset;

    logic                   fifo_full;
    logic                   accept;
    logic                   chunk_full;
    logic                   elem_end;
    logic                   push;
    logic                   pop;
    logic [LowDimWidth-1:0] packed_word;
    logic [LowDimWidth-1:0] push_data;

    // Decode slice width, slice mask, last chunk index and bit offset from the mode
    always_comb begin
        full_mode  = 1'b0;
        slice_mask = '0;
        last_chunk = '0;
        bit_offset = '0;
        case (sel_mode_i)
            ModeWidth'(1): begin
                slice_mask = LowDimWidth'(1);
                last_chunk = LastChunk1;
                bit_offset = chunk_q;
            end
            ModeWidth'(2): begin
                slice_mask = LowDimWidth'(4'hF);
                last_chunk = LastChunk4;
                bit_offset = chunk_q << 2;
            end
            ModeWidth'(3): begin
                slice_mask = LowDimWidth'(8'hFF);
                last_chunk = LastChunk8;
                bit_offset = chunk_q << 3;
            end
            default: begin
                full_mode  = 1'b1;
                slice_mask = '1;
            end
        endcase
    end

    assign fifo_full   = (count_q == FullCnt);
    // Held low while in reset so nothing is offered as accepted before the block is live
    assign in_ready_o  = rst_ni & enable_i & ~fifo_full;
    // A clear swallows any slice offered in the same cycle
    assign accept      = in_valid_i & in_ready_o & ~clr_i;
    assign chunk_full  = (chunk_q == last_chunk);
    assign elem_end    = (csr_elem_size_i != '0) &&
                         (elem_q == (csr_elem_size_i - CsrRegWidth'(1)));
    assign packed_word = asm_q | ((in_data_i & slice_mask) << bit_offset);
    assign push_data   = full_mode ? in_data_i : packed_word;
    assign push        = accept & (full_mode | chunk_full | elem_end);
    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    // Next state for the chunk/element counters and the assembly register
    always_comb begin
        chunk_d = chunk_q;
        elem_d  = elem_q;
        asm_d   = asm_q;
        if (clr_i || !enable_i) begin
            chunk_d = '0;
            elem_d  = '0;
            asm_d   = '0;
        end else if (accept && !full_mode) begin
            if (push) begin
                chunk_d = '0;
                asm_d   = '0;
            end else begin
                chunk_d = chunk_q + ChunkW'(1);
                asm_d   = packed_word;
            end
            elem_d = elem_end ? '0 : (elem_q + CsrRegWidth'(1));
        end
    end

    // Packer registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chunk_q <= '0;
            elem_q  <= '0;
            asm_q   <= '0;
        end else begin
            chunk_q <= chunk_d;
            elem_q  <= elem_d;
            asm_q   <= asm_d;
        end
    end

    // Next state for FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : (wr_ptr_q + PtrW'(1));
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : (rd_ptr_q + PtrW'(1));
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; stale entries are masked at the output by out_valid_o
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef DATA_PACKER_STATUS_EN
    logic [CsrRegWidth-1:0] word_count_q, word_count_d;

    // Wrapping count of pushed words, cleared with the FIFO
    always_comb begin
        word_count_d = word_count_q;
        if (clr_i) begin
            word_count_d = '0;
        end else if (push) begin
            word_count_d = word_count_q + CsrRegWidth'(1);
        end
    end

    // Word counter register with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count_o = word_count_q;
`endif

endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: randomized and directed stimulus for data_packer with a queue-based
// scoreboard. The reference model derives each slice position from its index within the
// current element and the word size, independent of any counter structure.
module tb_data_packer;

    logic        clk;
    logic        rst_ni;
    logic        enable_i;
    logic        clr_i;
    logic [1:0]  sel_mode_i;
    logic [31:0] csr_elem_size_i;
    logic [63:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
`ifdef DATA_PACKER_STATUS_EN
    logic [31:0] word_count_o;
`endif

    data_packer #(
        .LowDimWidth    (64),
        .CsrRegWidth    (32),
        .PackerFifoDepth(4),
        .ModeWidth      (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .clr_i          (clr_i),
        .sel_mode_i     (sel_mode_i),
        .csr_elem_size_i(csr_elem_size_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
`ifdef DATA_PACKER_STATUS_EN
        .word_count_o   (word_count_o),
`endif
        .out_ready_i    (out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    // Reference model state
    int          m_mode;
    int          m_size;
    int          m_idx;
    logic [63:0] m_acc;
    int unsigned m_words;

    logic        acc_l;
    int          n_acc;
    logic [63:0] d_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_idx = 0;
        m_acc = '0;
    endtask

    // One accepted slice: position = (index within element) mod slices-per-word
    task automatic model_accept(input logic [63:0] d);
        int          w;
        int          spw;
        int          k;
        int          chunk;
        logic [63:0] mask;
        if (m_mode == 0) begin
            exp_q.push_back(d);
            m_words++;
            return;
        end
        w     = (m_mode == 1) ? 1 : ((m_mode == 2) ? 4 : 8);
        spw   = 64 / w;
        mask  = (64'd1 << w) - 64'd1;
        k     = (m_size != 0) ? (m_idx % m_size) : m_idx;
        chunk = k % spw;
        m_acc = m_acc | ((d & mask) << (chunk * w));
        m_idx++;
        if ((chunk == spw - 1) || ((m_size != 0) && (k == m_size - 1))) begin
            exp_q.push_back(m_acc);
            m_words++;
            m_acc = '0;
        end
    endtask

    // Scoreboard monitor: compare every word the consumer pops
    always @(negedge clk) begin
        if (rst_ni && !clr_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected no word", out_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_word", out_data_o, mon_exp);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic drive_cycle(input logic v, input logic [63:0] d, input logic c,
                               input logic e, input logic r, output logic acc);
        in_valid_i  = v;
        in_data_i   = d;
        clr_i       = c;
        enable_i    = e;
        out_ready_i = r;
        @(negedge clk);
        acc = v && in_ready_o && !c;
        if (c) begin
            exp_q.delete();
            model_clear();
            m_words = 0;
        end else if (!e) begin
            model_clear();
        end else if (acc) begin
            model_accept(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic r);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive_cycle(1'b1, d, 1'b0, 1'b1, r, acc);
            n++;
        end while (!acc && n < 50);
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    endtask

    task automatic configure(input int mode, input int size);
        logic acc;
        sel_mode_i      = 2'(mode);
        csr_elem_size_i = 32'(size);
        m_mode          = mode;
        m_size          = size;
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sizes[9] = '{0, 1, 3, 7, 10, 16, 64, 65, 100};
        m_mode = 1; m_size = 64; m_words = 0;
        model_clear();
        rst_ni          = 1'b0;
        enable_i        = 1'b1;
        clr_i           = 1'b0;
        in_valid_i      = 1'b1;
        in_data_i       = '1;
        out_ready_i     = 1'b1;
        sel_mode_i      = 2'd1;
        csr_elem_size_i = 32'd64;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", out_data_o, 64'd0);
        in_valid_i = 1'b0;
        @(posedge clk); #3; rst_ni = 1'b1;
        @(posedge clk); #1;

        // Mode 1, alternating bits, junk in upper bits
        configure(1, 64);
        for (int i = 0; i < 64; i++) begin
            d_l    = {$urandom, $urandom};
            d_l[0] = (i % 2 == 0);
            send(d_l, 1'b1);
            if (i == 62) check("m1_no_early_valid", 64'(out_valid_o), 64'd0);
        end
        check("m1_valid_next", 64'(out_valid_o), 64'd1);
        check("m1_word", out_data_o, 64'h5555555555555555);
        idle(3);

        // Mode 3, element size 10
        configure(3, 10);
        for (int i = 1; i <= 10; i++) send(64'(i), 1'b1);
        idle(3);

        // Mode 2, unbounded element, consumer stalled until FIFO fills
        configure(2, 0);
        n_acc = 0;
        for (int i = 0; i < 80; i++) begin
            drive_cycle(1'b1, {$urandom, $urandom} | 64'hF, 1'b0, 1'b1, 1'b0, acc_l);
            if (acc_l) n_acc++;
        end
        check("m2_accepted_until_full", 64'(n_acc), 64'd64);
        check("m2_full_ready_low", 64'(in_ready_o), 64'd0);
        check("m2_full_valid", 64'(out_valid_o), 64'd1);
        for (int i = 0; i < 16; i++) send({$urandom, $urandom} | 64'hF, 1'b1);
        idle(8);

        // Mode 0 pass-through, consecutive cycles
        configure(0, 0);
        drive_cycle(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 1'b1, acc_l);
        check("m0_acc0", 64'(acc_l), 64'd1);
        check("m0_valid0", 64'(out_valid_o), 64'd1);
        check("m0_word0", out_data_o, 64'hDEADBEEFCAFEF00D);
        drive_cycle(1'b1, 64'h1, 1'b0, 1'b1, 1'b1, acc_l);
        check("m0_valid1", 64'(out_valid_o), 64'd1);
        check("m0_word1", out_data_o, 64'h1);
        idle(3);

        // Clear drops both the partial word and FIFO contents
        configure(3, 0);
        for (int i = 0; i < 8; i++) send(64'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 3; i++) send(64'($urandom_range(0, 255)), 1'b0);
        drive_cycle(1'b1, 64'hAB, 1'b1, 1'b1, 1'b0, acc_l);
        check("clr_fifo_empty", 64'(out_valid_o), 64'd0);
        for (int i = 0; i < 8; i++) send(64'(8'h10 + i), 1'b1);
        check("clr_word_valid", 64'(out_valid_o), 64'd1);
        check("clr_word", out_data_o, 64'h1716151413121110);
        idle(3);

        // Reset mid-word with a word waiting in the FIFO
        configure(1, 64);
        for (int i = 0; i < 69; i++) send({$urandom, $urandom}, 1'b0);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        model_clear();
        m_words = 0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready_o), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_out_data", out_data_o, 64'd0);
        in_valid_i = 1'b0;
        @(posedge clk); #3; rst_ni = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) send({$urandom, $urandom}, 1'b1);
        idle(3);

        // Randomized blocks
        for (int b = 0; b < 12; b++) begin
            configure($urandom_range(0, 3), sizes[$urandom_range(0, 8)]);
            for (int i = 0; i < 150; i++) begin
                drive_cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
                            $urandom_range(0, 60) == 0, $urandom_range(0, 40) != 0,
                            $urandom_range(0, 3) != 0, acc_l);
            end
        end

        // Drain and confirm nothing is left over
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid_o); i++) idle(1);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_valid_low", 64'(out_valid_o), 64'd0);
`ifdef DATA_PACKER_STATUS_EN
        check("word_count", 64'(word_count_o), 64'(m_words));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
